i2c_arbiter: RTL and testbench
==============================

# i2c_arbiter

Shares one I2C `master` between two requesters and sequences each transaction. It grants one requester at a time round-robin, drives the master's `rw`/`data_in`, and releases the master from reset to start a transfer. It watches the master `state` for DONE, then returns the read byte and re-parks the master in reset. It sits between client logic (e.g. sensor pollers) and the `master` instance.

## Interface
- `TIMEOUT`, default 2000: RUN-state cycle limit before abort. Used only with the watchdog macro.
- `TW`, default 16: watchdog counter width. Must satisfy 2^TW > TIMEOUT.
- `clk` in 1: single clock. All logic is on posedge.
- `rst` in 1: asynchronous, active-low reset. The block is in reset while `rst`=0.
- `req` in 2: per-requester transaction request, level. Must be held until `done`.
- `req_rw` in 2: per-requester direction. 1=READ, 0=WRITE.
- `req_wdata0` in 8: write byte, requester 0.
- `req_wdata1` in 8: write byte, requester 1.
- `gnt` out 2: one-hot grant, high GRANT..FINISH.
- `done` out 2: one-cycle completion pulse to the granted requester.
- `rdata` out 8: byte captured from the master at DONE. Valid with `done`.
- `err` out 1: one-cycle pulse with `done` on watchdog abort.
- `m_rst` out 1: master reset, active-high. 1 holds the master idle.
- `m_rw` out 1: to master `rw`.
- `m_data_in` out 8: to master `data_in`.
- `m_data_out` in 8: from master `data_out`.
- `m_state` in 3: from master `state`. Encodings: IDLE=0, ADDRESSING=1, WAITING=2, READING=3, WRITING=4, DONE=5.

## Operation
- Reset values:
  - `gnt`=0, `done`=0, `err`=0, `rdata`=0
  - `m_rst`=1, `m_rw`=1, `m_data_in`=0
  - `last`=1, so requester 0 wins the first tie
  - FSM in IDLE, watchdog counter=0
- FSM state IDLE: `m_rst`=1. If any `req` bit is set, pick the winner and go to GRANT.
  - Single request: that requester wins.
  - Both requesting: the requester ≠ `last` wins.
- FSM state GRANT, 1 cycle: `gnt[w]`=1. `m_rw`←`req_rw[w]`; `m_data_in`←`req_wdata{w}`. `m_rst` stays 1, so the master sees stable inputs before release. Next state: RUN.
- FSM state RUN: `m_rst`=0 and the master runs its transfer. On `m_state`==5 go to FINISH.
  - `rdata`←`m_data_out` only if `m_rw`=1. A write leaves `rdata` unchanged.
- FSM state FINISH, 1 cycle: `m_rst`=1, `done[w]`=1, `last`←w. Next state: IDLE.
- `m_rw` and `m_data_in` are frozen from GRANT until the next GRANT.
- A requester input change (`req`, `req_rw`, wdata) after GRANT has no effect on the current transaction.
- Dropping `req` mid-transaction does not abort. The transaction completes and `done` still pulses.
- `m_state` values 6/7 in RUN are ignored: stay in RUN.
- Reset mid-operation: all outputs go to reset values immediately (async), and the master is re-parked via `m_rst`=1. No `done` is issued for the aborted transaction.

## Timing
- `req` sampled high in IDLE at edge k:
  - `gnt` high after edge k.
  - `m_rst` low after edge k+1.
- `m_state`==5 sampled at edge j in RUN: `done`, `rdata` and `m_rst`=1 valid after edge j. `gnt` drops after edge j+1.
- Minimum one IDLE cycle between transactions. Back-to-back grant to the other requester: `gnt` re-asserts after edge j+2.
- All outputs are registered. There is no combinational input-to-output path.

## Configuration
- `I2C_ARB_TIMEOUT_EN` defined:
  - The watchdog counter increments each RUN cycle and clears on entering RUN.
  - When the counter equals TIMEOUT-1, the FSM goes to FINISH with `err`=1 and `done[w]`=1; `rdata` is unchanged.
- `I2C_ARB_TIMEOUT_EN` undefined:
  - No counter is built, and `err` is tied 0.
  - RUN waits indefinitely for DONE.

## Test plan
- Single read: requester 0, `req_rw`=1; master model returns 8'hF6.
  - → `gnt`=01, then `m_rst` falls one cycle after `gnt`.
  - → `done`=01 pulse with `rdata`=F6, `m_rst`=1 in the same cycle.
- Single write: requester 1, `req_rw`=0, `req_wdata1`=8'h5A.
  - → `m_rw`=0 and `m_data_in`=5A in GRANT, stable until DONE.
  - → `done`=10; `rdata` holds its previous value.
- Simultaneous `req`=11 out of reset:
  - → requester 0 granted first, then requester 1 granted two cycles after `done`=01.
  - → Repeating `req`=11 alternates 0,1,0,1.
- `req` dropped during RUN → transfer completes and the `done` pulse still occurs.
- Timeout (macro on, TIMEOUT=50), master stuck in state 3:
  - → `err` and `done` pulse exactly 50 RUN cycles after `m_rst` fell, and `m_rst` returns to 1.
  - → With the macro off, the FSM is still in RUN after 5000 cycles.
- Reset: `rst`=0 asserted mid-RUN → `m_rst`=1 and `gnt`=0 immediately; no `done` pulse; a new request after release is served normally.

Source files
------------

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that lends one I2C master to two requesters and sequences each transfer.
// Optional RUN-state watchdog abort is built when I2C_ARB_TIMEOUT_EN is defined.
module i2c_arbiter #(
  parameter int TIMEOUT = 2000,
  parameter int TW      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] req_rw,
  input  logic [7:0] req_wdata0,
  input  logic [7:0] req_wdata1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       err,
  output logic       m_rst,
  output logic       m_rw,
  output logic [7:0] m_data_in,
  input  logic [7:0] m_data_out,
  input  logic [2:0] m_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [2:0] M_DONE = 3'd5;

  if ((64'd1 << TW) <= 64'(TIMEOUT)) begin : g_tw_check
    $error("i2c_arbiter: TW too narrow to hold TIMEOUT");
  end

  state_t     state_r, state_s;
  logic       win_r, win_s;
  logic       last_r, last_s;
  logic       pick_s;
  logic [1:0] gnt_r, gnt_s;
  logic [1:0] done_r, done_s;
  logic [7:0] rdata_r, rdata_s;
  logic       m_rst_r, m_rst_s;
  logic       m_rw_r, m_rw_s;
  logic [7:0] m_data_in_r, m_data_in_s;
  logic       timeout_s;
  logic       err_s;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wd_cnt_r, wd_cnt_s;
  logic          err_r;
`endif

  // Next-state and next-output computation for the transaction sequencer
  always_comb begin
    state_s     = state_r;
    win_s       = win_r;
    last_s      = last_r;
    gnt_s       = gnt_r;
    done_s      = 2'b00;
    rdata_s     = rdata_r;
    m_rst_s     = m_rst_r;
    m_rw_s      = m_rw_r;
    m_data_in_s = m_data_in_r;
    err_s       = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    wd_cnt_s    = wd_cnt_r;
    timeout_s   = (wd_cnt_r == WD_LAST);
`else
    timeout_s   = 1'b0;
`endif

    // On a tie the requester that did not go last wins
    if (req == 2'b11) begin
      pick_s = ~last_r;
    end else begin
      pick_s = req[1];
    end

    case (state_r)
      IDLE: begin
        m_rst_s = 1'b1;
        if (req != 2'b00) begin
          state_s     = GRANT;
          win_s       = pick_s;
          gnt_s       = pick_s ? 2'b10 : 2'b01;
          m_rw_s      = req_rw[pick_s];
          m_data_in_s = pick_s ? req_wdata1 : req_wdata0;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        state_s = RUN;
        m_rst_s = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        wd_cnt_s = '0;
`endif
      end
      RUN: begin
        if (m_state == M_DONE) begin
          state_s = FINISH;
          m_rst_s = 1'b1;
          done_s  = win_r ? 2'b10 : 2'b01;
          if (m_rw_r) begin
            rdata_s = m_data_out;
          end else begin
            rdata_s = rdata_r;
          end
        end else if (timeout_s) begin
          state_s = FINISH;
          m_rst_s = 1'b1;
          done_s  = win_r ? 2'b10 : 2'b01;
          err_s   = 1'b1;
        end else begin
          state_s = RUN;
`ifdef I2C_ARB_TIMEOUT_EN
          wd_cnt_s = wd_cnt_r + TW'(1);
`endif
        end
      end
      FINISH: begin
        state_s = IDLE;
        gnt_s   = 2'b00;
        last_s  = win_r;
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 2'b00;
        m_rst_s = 1'b1;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      win_r       <= 1'b0;
      last_r      <= 1'b1;
      gnt_r       <= 2'b00;
      done_r      <= 2'b00;
      rdata_r     <= 8'h00;
      m_rst_r     <= 1'b1;
      m_rw_r      <= 1'b1;
      m_data_in_r <= 8'h00;
    end else begin
      state_r     <= state_s;
      win_r       <= win_s;
      last_r      <= last_s;
      gnt_r       <= gnt_s;
      done_r      <= done_s;
      rdata_r     <= rdata_s;
      m_rst_r     <= m_rst_s;
      m_rw_r      <= m_rw_s;
      m_data_in_r <= m_data_in_s;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  // Watchdog counter and abort flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_r <= '0;
      err_r    <= 1'b0;
    end else begin
      wd_cnt_r <= wd_cnt_s;
      err_r    <= err_s;
    end
  end

  assign err = err_r;
`else
  assign err = err_s & 1'b0;
`endif

  assign gnt       = gnt_r;
  assign done      = done_r;
  assign rdata     = rdata_r;
  assign m_rst     = m_rst_r;
  assign m_rw      = m_rw_r;
  assign m_data_in = m_data_in_r;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed and randomized transactions against a
// round-robin reference model, plus watchdog and asynchronous-reset scenarios.
module tb_i2c_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, req_rw;
  logic [7:0] req_wdata0, req_wdata1;
  logic [1:0] gnt, done;
  logic [7:0] rdata;
  logic       err, m_rst, m_rw;
  logic [7:0] m_data_in, m_data_out;
  logic [2:0] m_state;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  int         last_w;
  logic [7:0] exp_rdata;

  i2c_arbiter #(.TIMEOUT(50), .TW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_rw     (req_rw),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .gnt        (gnt),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .m_rst      (m_rst),
    .m_rw       (m_rw),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .m_state    (m_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Busy master states, including the undefined 6/7 codes
  function automatic logic [2:0] pick_busy();
    logic [2:0] v;
    v = 3'($urandom_range(1, 6));
    if (v == 3'd5) v = 3'd7;
    return v;
  endfunction

  function automatic int model_winner(input logic [1:0] rq);
    if (rq == 2'b11) return 1 - last_w;
    return rq[1] ? 1 : 0;
  endfunction

  // Issue a request at the current negedge and check grant and master release
  task automatic start_to_run(input logic [1:0] rq, input logic [1:0] rw,
                              input logic [7:0] w0, input logic [7:0] w1,
                              output int w);
    logic [1:0] oh;
    w  = model_winner(rq);
    oh = (w == 1) ? 2'b10 : 2'b01;
    req = rq; req_rw = rw; req_wdata0 = w0; req_wdata1 = w1; m_state = 3'd0;
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(oh));
    check("grant_m_rst", 32'(m_rst), 32'd1);
    check("grant_m_rw", 32'(m_rw), 32'(rw[w]));
    check("grant_m_data_in", 32'(m_data_in), 32'((w == 1) ? w1 : w0));
    @(negedge clk);
    check("run_m_rst", 32'(m_rst), 32'd0);
  endtask

  task automatic run_txn(input logic [1:0] rq, input logic [1:0] rw,
                         input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] mdata, input bit drop);
    int         w, n;
    logic [1:0] oh;
    logic       e_rw;
    logic [7:0] e_wd;
    start_to_run(rq, rw, w0, w1, w);
    oh   = (w == 1) ? 2'b10 : 2'b01;
    e_rw = rw[w];
    e_wd = (w == 1) ? w1 : w0;
    n    = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      m_state    = pick_busy();
      req_rw     = 2'($urandom);
      req_wdata0 = 8'($urandom);
      req_wdata1 = 8'($urandom);
      if (drop) req = 2'b00;
      @(negedge clk);
      check("run_no_done", 32'(done), 32'd0);
    end
    m_state = 3'd5; m_data_out = mdata;
    @(negedge clk);
    if (e_rw) exp_rdata = mdata;
    check("done", 32'(done), 32'(oh));
    check("rdata", 32'(rdata), 32'(exp_rdata));
    check("done_m_rst", 32'(m_rst), 32'd1);
    check("done_gnt", 32'(gnt), 32'(oh));
    check("done_err", 32'(err), 32'd0);
    check("frozen_m_rw", 32'(m_rw), 32'(e_rw));
    check("frozen_m_data_in", 32'(m_data_in), 32'(e_wd));
    m_state = 3'd0; req = 2'b00;
    @(negedge clk);
    check("done_pulse_end", 32'(done), 32'd0);
    check("gnt_drop", 32'(gnt), 32'd0);
    last_w = w;
  endtask

  initial begin
    int         w, first;
    logic [1:0] rq;
    logic       f_err, f_mrst;
    logic [1:0] f_done;
    logic [7:0] f_rdata;
    bit         saw_done;

    rst = 1'b0; req = 2'b00; req_rw = 2'b00; req_wdata0 = 8'h00; req_wdata1 = 8'h00;
    m_state = 3'd0; m_data_out = 8'h00; last_w = 1; exp_rdata = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_m_rst", 32'(m_rst), 32'd1);
    check("rst_m_rw", 32'(m_rw), 32'd1);
    check("rst_m_data_in", 32'(m_data_in), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_txn(2'b01, 2'b01, 8'h00, 8'h00, 8'hF6, 1'b0);
    run_txn(2'b10, 2'b00, 8'h11, 8'h5A, 8'h99, 1'b0);
    repeat (4) run_txn(2'b11, 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    run_txn(2'b01, 2'b01, 8'h00, 8'h00, 8'h3C, 1'b1);
    run_txn(2'b10, 2'b10, 8'h00, 8'h00, 8'hA7, 1'b1);
    repeat (12) begin
      rq = 2'($urandom_range(1, 3));
      run_txn(rq, 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Master stuck in READING
    start_to_run(2'b01, 2'b01, 8'h00, 8'h00, w);
    m_state = 3'd3; req = 2'b00;
`ifdef I2C_ARB_TIMEOUT_EN
    first = -1; f_err = 1'bx; f_mrst = 1'bx; f_done = 2'bxx; f_rdata = 8'hxx;
    for (int i = 1; i <= 60 && first < 0; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        first = i; f_err = err; f_mrst = m_rst; f_done = done; f_rdata = rdata;
      end
    end
    check("timeout_cycles", 32'(first), 32'd50);
    check("timeout_done", 32'(f_done), 32'd1);
    check("timeout_err", 32'(f_err), 32'd1);
    check("timeout_m_rst", 32'(f_mrst), 32'd1);
    check("timeout_rdata", 32'(f_rdata), 32'(exp_rdata));
    @(negedge clk);
    check("timeout_err_end", 32'(err), 32'd0);
    last_w = 0;
    m_state = 3'd0;
    start_to_run(2'b10, 2'b10, 8'h00, 8'h00, w);
`else
    saw_done = 1'b0;
    repeat (5000) begin
      @(negedge clk);
      if (done != 2'b00) saw_done = 1'b1;
    end
    check("stuck_no_done", 32'(saw_done), 32'd0);
    check("stuck_in_run", 32'(m_rst), 32'd0);
    check("stuck_gnt", 32'(gnt), 32'd1);
`endif

    // Asynchronous reset while the master is running
    m_state = 3'd2;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_m_rst", 32'(m_rst), 32'd1);
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_rdata", 32'(rdata), 32'd0);
    check("arst_m_rw", 32'(m_rw), 32'd1);
    exp_rdata = 8'h00; last_w = 1;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done != 2'b00) saw_done = 1'b1;
    end
    check("arst_no_done", 32'(saw_done), 32'd0);
    rst = 1'b1; m_state = 3'd0;
    @(negedge clk);
    run_txn(2'b11, 2'b11, 8'h00, 8'h00, 8'hC3, 1'b0);
    run_txn(2'b11, 2'b01, 8'h00, 8'h77, 8'h12, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
